// File: rtl/input_deserializer_if.sv
// Serial-in / parallel-out bundle between an element source, the deserializer
// and the layer that consumes whole frames.
interface input_deserializer_if #(
    parameter int unsigned dataWidth = 8,
    parameter int unsigned numInputs = 784
);
    localparam int unsigned countWidth = $clog2(numInputs + 1);

    logic [dataWidth-1:0]           serialIn;
    logic                           serialValid;
    logic                           serialLast;
    logic                           serialReady;
    logic [dataWidth*numInputs-1:0] parallelOut;
    logic                           parallelValid;
    logic                           parallelAck;
    logic                           frameError;
    logic [countWidth-1:0]          fillCount;

    // Upstream source plus downstream consumer side.
    modport master (
        output serialIn, serialValid, serialLast, parallelAck,
        input  serialReady, parallelOut, parallelValid, frameError, fillCount
    );

    // Deserializer side.
    modport slave (
        input  serialIn, serialValid, serialLast, parallelAck,
        output serialReady, parallelOut, parallelValid, frameError, fillCount
    );
endinterface

// File: rtl/input_deserializer.sv
// Collects numInputs serial elements into one wide frame register, then holds
// the frame with parallelValid high until the consumer acknowledges it.
module input_deserializer #(
    parameter int unsigned dataWidth = 8,
    parameter int unsigned numInputs = 784
) (
    input logic                    clk,
    input logic                    reset,
    input_deserializer_if.slave    bus
);
    localparam int unsigned countWidth = $clog2(numInputs + 1);
    localparam logic [countWidth-1:0] LastIdx = countWidth'(numInputs - 1);

    typedef enum logic [0:0] {StCollect, StHold} state_e;

    state_e                         state_q, state_d;
    logic [countWidth-1:0]          fill_q, fill_d;
    logic [dataWidth*numInputs-1:0] data_q, data_d;
    logic                           valid_q, valid_d;
    logic                           err_q, err_d;
    logic                           accept;
    logic                           is_final;

    assign bus.serialReady   = (state_q == StCollect);
    assign accept            = bus.serialValid && (state_q == StCollect);
    assign is_final          = (fill_q == LastIdx);

    assign bus.parallelOut   = data_q;
    assign bus.parallelValid = valid_q;
    assign bus.frameError    = err_q;
    assign bus.fillCount     = fill_q;

    // Write the accepted element into the slot selected by the fill count;
    // a short-frame terminator is still written, it simply is not kept as a frame.
    always_comb begin
        data_d = data_q;
        for (int unsigned i = 0; i < numInputs; i++) begin
            if (accept && (fill_q == countWidth'(i))) begin
                data_d[i*dataWidth +: dataWidth] = bus.serialIn;
            end
        end
    end

    // Frame FSM: count beats, detect short/long frames, hold until ack.
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        unique case (state_q)
            StCollect: begin
                if (accept) begin
                    if (is_final) begin
                        state_d = StHold;
                        fill_d  = fill_q + countWidth'(1);
                        valid_d = 1'b1;
                        err_d   = !bus.serialLast;
                    end else if (bus.serialLast) begin
                        fill_d  = '0;
                        err_d   = 1'b1;
                    end else begin
                        fill_d  = fill_q + countWidth'(1);
                    end
                end
            end
            StHold: begin
                if (bus.parallelAck) begin
                    state_d = StCollect;
                    fill_d  = '0;
                    valid_d = 1'b0;
                end
            end
        endcase
    end

    // State and frame registers; reset discards any partial or held frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StCollect;
            fill_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end
endmodule
